// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_arbiter
// Brief    : Two-port (CPU / loader) arbiter in front of a single LSU with
//            bounded-wait fairness and in-order load-return steering.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [2:0]  i_m0_func3,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [2:0]  i_m1_func3,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic        o_lsu_wren,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_st_data,
    output logic [2:0]  o_func3,
    input  logic [31:0] i_ld_data,
    output logic [1:0]  o_owner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } owner_t;

    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    owner_t      r_owner;
    owner_t      w_owner_nxt;
    logic [3:0]  r_wait;
    logic [3:0]  w_wait_nxt;
    logic [3:0]  w_wait_inc;
    logic        r_rv0;
    logic        r_rv1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner <= ST_IDLE;
            r_wait  <= 4'd0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            r_wait  <= w_wait_nxt;
            r_rv0   <= o_m0_gnt & ~i_m0_we;
            r_rv1   <= o_m1_gnt & ~i_m1_we;
        end
    end

    // The counter stores at most MAX_WAIT-1; reaching MAX_WAIT hands over at once.
    always_comb begin
        w_owner_nxt = r_owner;
        w_wait_nxt  = 4'd0;
        w_wait_inc  = r_wait + 4'd1;
        case (r_owner)
            ST_IDLE: begin
                if (i_m0_req)      w_owner_nxt = ST_OWN0;
                else if (i_m1_req) w_owner_nxt = ST_OWN1;
            end
            ST_OWN0: begin
                if (!i_m0_req) begin
                    w_owner_nxt = i_m1_req ? ST_OWN1 : ST_IDLE;
                end else if (i_m1_req) begin
                    if (w_wait_inc >= c_MAX_WAIT) w_owner_nxt = ST_OWN1;
                    else                          w_wait_nxt  = w_wait_inc;
                end
            end
            ST_OWN1: begin
                if (!i_m1_req) begin
                    w_owner_nxt = i_m0_req ? ST_OWN0 : ST_IDLE;
                end else if (i_m0_req) begin
                    if (w_wait_inc >= c_MAX_WAIT) w_owner_nxt = ST_OWN0;
                    else                          w_wait_nxt  = w_wait_inc;
                end
            end
            default: w_owner_nxt = ST_IDLE;
        endcase
    end

    assign o_m0_gnt = (r_owner == ST_OWN0) && i_m0_req;
    assign o_m1_gnt = (r_owner == ST_OWN1) && i_m1_req;
    assign o_owner  = r_owner;

    always_comb begin
        o_lsu_wren = 1'b0;
        o_lsu_addr = 32'd0;
        o_st_data  = 32'd0;
        o_func3    = 3'd0;
        if (o_m0_gnt) begin
            o_lsu_wren = i_m0_we;
            o_lsu_addr = i_m0_addr;
            o_st_data  = i_m0_wdata;
            o_func3    = i_m0_func3;
        end else if (o_m1_gnt) begin
            o_lsu_wren = i_m1_we;
            o_lsu_addr = i_m1_addr;
            o_st_data  = i_m1_wdata;
            o_func3    = i_m1_func3;
        end
    end

    assign o_m0_rvalid = r_rv0;
    assign o_m1_rvalid = r_rv1;
    assign o_m0_rdata  = r_rv0 ? i_ld_data : 32'd0;
    assign o_m1_rdata  = r_rv1 ? i_ld_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_arbiter
// Brief    : Directed vector table plus starvation / reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_arbiter;

    localparam logic [31:0] c_M0_WD = 32'h1111_2222;
    localparam logic [2:0]  c_F0    = 3'b010;
    localparam logic [2:0]  c_F1    = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m1_addr, m1_wdata, ld_data;
    logic        m0_gnt, m1_gnt, m0_rv, m1_rv, lsu_wren;
    logic [31:0] m0_rd, m1_rd, lsu_addr, st_data;
    logic [2:0]  func3;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_arbiter #(.MAX_WAIT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_wdata(c_M0_WD), .i_m0_func3(c_F0),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rv), .o_m0_rdata(m0_rd),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_func3(c_F1),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rv), .o_m1_rdata(m1_rd),
        .o_lsu_wren(lsu_wren), .o_lsu_addr(lsu_addr), .o_st_data(st_data),
        .o_func3(func3), .i_ld_data(ld_data), .o_owner(owner)
    );

    typedef struct {
        logic r0, w0; logic [31:0] a0;
        logic r1, w1; logic [31:0] a1, d1;
        logic [31:0] ld;
        logic [1:0] own; logic g0, g1, wren; logic [31:0] addr;
        logic v0, v1; logic [31:0] rd0, rd1;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [31:0] a0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
        input logic [31:0] ld,
        input logic [1:0] own, input logic g0, input logic g1, input logic wren,
        input logic [31:0] addr, input logic v0, input logic v1,
        input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.ld = ld; v.own = own; v.g0 = g0; v.g1 = g1; v.wren = wren; v.addr = addr;
        v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive after the rising edge; the caller samples half a period later.
    task automatic drive(input logic r, input logic r0, input logic w0, input logic [31:0] a0,
                         input logic r1, input logic w1, input logic [31:0] a1,
                         input logic [31:0] d1, input logic [31:0] ld);
        @(posedge clk);
        #1;
        rst = r; m0_req = r0; m0_we = w0; m0_addr = a0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; ld_data = ld;
        #4;
    endtask

    task automatic chk_all(input int idx, input logic [1:0] own, input logic g0,
                           input logic g1, input logic wren, input logic [31:0] addr,
                           input logic v0, input logic v1,
                           input logic [31:0] rd0, input logic [31:0] rd1);
        logic [31:0] st;
        logic [2:0]  f3;
        st = g0 ? c_M0_WD : (g1 ? m1_wdata : 32'd0);
        f3 = g0 ? c_F0 : (g1 ? c_F1 : 3'd0);
        chk("owner", idx, 32'(owner), 32'(own));
        chk("gnt0", idx, 32'(m0_gnt), 32'(g0));
        chk("gnt1", idx, 32'(m1_gnt), 32'(g1));
        chk("wren", idx, 32'(lsu_wren), 32'(wren));
        chk("addr", idx, lsu_addr, addr);
        chk("st_data", idx, st_data, st);
        chk("func3", idx, 32'(func3), 32'(f3));
        chk("rvalid0", idx, 32'(m0_rv), 32'(v0));
        chk("rvalid1", idx, 32'(m1_rv), 32'(v1));
        chk("rdata0", idx, m0_rd, rd0);
        chk("rdata1", idx, m1_rd, rd1);
    endtask

    initial begin
        logic g0, g1, pg0, pg1;
        logic [1:0]  own;
        logic [31:0] ld;

        // Single load, store, release-to-other, then idle.
        tbl[0]  = mk(1,0,32'h10, 0,0,0,0, 0,            2'd0,0,0,0,0,           0,0,0,0);
        tbl[1]  = mk(1,0,32'h10, 0,0,0,0, 0,            2'd1,1,0,0,32'h10,      0,0,0,0);
        tbl[2]  = mk(0,0,0, 0,0,0,0, 32'hDEADBEEF,      2'd1,0,0,0,0,           1,0,32'hDEADBEEF,0);
        tbl[3]  = mk(0,0,0, 0,0,0,0, 32'h12345678,      2'd0,0,0,0,0,           0,0,0,0);
        tbl[4]  = mk(0,0,0, 1,1,32'h1000_0000,32'hFF, 0, 2'd0,0,0,0,0,          0,0,0,0);
        tbl[5]  = mk(0,0,0, 1,1,32'h1000_0000,32'hFF, 0, 2'd2,0,1,1,32'h1000_0000, 0,0,0,0);
        tbl[6]  = mk(0,0,0, 0,0,0,0, 32'hAAAA5555,      2'd2,0,0,0,0,           0,0,0,0);
        tbl[7]  = mk(1,0,32'h20, 0,0,0,0, 0,            2'd0,0,0,0,0,           0,0,0,0);
        tbl[8]  = mk(1,0,32'h20, 1,1,32'h44,32'h55, 0,  2'd1,1,0,0,32'h20,      0,0,0,0);
        tbl[9]  = mk(0,0,0, 1,1,32'h44,32'h55, 32'hCAFEF00D, 2'd1,0,0,0,0,      1,0,32'hCAFEF00D,0);
        tbl[10] = mk(0,0,0, 1,1,32'h44,32'h55, 0,       2'd2,0,1,1,32'h44,      0,0,0,0);
        tbl[11] = mk(0,0,0, 0,0,0,0, 0,                 2'd2,0,0,0,0,           0,0,0,0);
        tbl[12] = mk(0,0,0, 0,0,0,0, 0,                 2'd0,0,0,0,0,           0,0,0,0);

        rst = 1'b1; m0_req = 0; m0_we = 0; m0_addr = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; ld_data = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 13; i++) begin
            drive(1'b0, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].r1, tbl[i].w1,
                  tbl[i].a1, tbl[i].d1, tbl[i].ld);
            chk_all(i, tbl[i].own, tbl[i].g0, tbl[i].g1, tbl[i].wren, tbl[i].addr,
                    tbl[i].v0, tbl[i].v1, tbl[i].rd0, tbl[i].rd1);
        end

        // Both ports load continuously: 4 cycles each; reset hits in the OWN1 phase.
        pg0 = 0; pg1 = 0;
        for (int c = 0; c < 8; c++) begin
            ld = 32'hA000_0000 + 32'(c);
            drive((c == 7), 1, 0, 32'h100, 1, 0, 32'h200, 32'h3333, ld);
            g0  = (c >= 1) && ((((c - 1) / 4) % 2) == 0);
            g1  = (c >= 1) && !g0;
            own = (c == 0) ? 2'd0 : (g0 ? 2'd1 : 2'd2);
            chk_all(100 + c, own, g0, g1, 1'b0, g0 ? 32'h100 : (g1 ? 32'h200 : 32'h0),
                    pg0, pg1, pg0 ? ld : 32'h0, pg1 ? ld : 32'h0);
            pg0 = g0; pg1 = g1;
        end

        // Load granted during reset returns nothing; m0 wins the rearbitration.
        drive(0, 1, 0, 32'h100, 1, 0, 32'h200, 32'h3333, 32'hBBBB_0001);
        chk_all(200, 2'd0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        drive(0, 1, 0, 32'h100, 1, 0, 32'h200, 32'h3333, 32'hBBBB_0002);
        chk_all(201, 2'd1, 1, 0, 0, 32'h100, 0, 0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'hBBBB_0003);
        chk_all(202, 2'd1, 0, 0, 0, 32'h0, 1, 0, 32'hBBBB_0003, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
